// File: rtl/fpu_ss_dispatch_ctrl.sv
// fpu_ss_dispatch_ctrl: gates offloaded FP instructions on commit, operand/WAW hazards and in-flight limit
module fpu_ss_dispatch_ctrl #(
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter int NUM_WB       = 2,
  parameter int FORWARDING   = 1,
  parameter int OUT_OF_ORDER = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ID_WIDTH-1:0]   in_id_i,
  input  logic [14:0]           in_rs_i,
  input  logic [2:0]            in_use_rs_i,
  input  logic [4:0]            in_rd_i,
  input  logic                  in_rd_is_fp_i,
  input  logic                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  disp_valid_o,
  input  logic                  disp_ready_i,
  output logic                  disp_drop_o,
  input  logic                  retire_i,
  input  logic [NUM_WB-1:0]     wb_valid_i,
  input  logic [5*NUM_WB-1:0]   wb_rd_i,
  output logic [3*NUM_WB-1:0]   fwd_sel_o,
  output logic [3:0]            inflight_o,
  output logic [31:0]           stall_cnt_o,
  output logic                  busy_o
);
  localparam int NID = 1 << ID_WIDTH;
  localparam logic [3:0] LIMIT = OUT_OF_ORDER != 0 ? 4'(MAX_INFLIGHT) : 4'd1;
  logic [NID-1:0] c_q, k_q;
  logic [31:0] pend_q, wb_clr, stall_q;
  logic [3:0] inflight_q;
  logic [2:0] stall_k;
  logic same, go, dead, waw, wb_rd_hit, limit, hs, drop;
  always_comb begin
    fwd_sel_o = '0;
    stall_k = '0;
    wb_clr = '0;
    wb_rd_hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      // descending scan leaves the lowest matching port selected
      for (int p = NUM_WB - 1; p >= 0; p--)
        if (FORWARDING != 0 && wb_valid_i[p] && wb_rd_i[5*p +: 5] == in_rs_i[5*k +: 5]) begin
          fwd_sel_o[k*NUM_WB +: NUM_WB] = '0;
          fwd_sel_o[k*NUM_WB + p] = 1'b1;
        end
      stall_k[k] = in_use_rs_i[k] & pend_q[in_rs_i[5*k +: 5]] & ~|fwd_sel_o[k*NUM_WB +: NUM_WB];
    end
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid_i[p]) begin
        wb_clr[wb_rd_i[5*p +: 5]] = 1'b1;
        wb_rd_hit = wb_rd_hit | (wb_rd_i[5*p +: 5] == in_rd_i);
      end
  end
  assign same = commit_valid_i & (commit_id_i == in_id_i);
  assign go = c_q[in_id_i] | (same & ~commit_kill_i);
  assign dead = k_q[in_id_i] | (same & commit_kill_i);
  assign waw = in_rd_is_fp_i & pend_q[in_rd_i] & ~wb_rd_hit;
  assign limit = (inflight_q == LIMIT) & ~retire_i;
  assign disp_valid_o = in_valid_i & go & ~dead & ~|stall_k & ~waw & ~limit;
  assign drop = in_valid_i & dead;
  assign disp_drop_o = drop;
  assign hs = disp_valid_o & disp_ready_i;
  assign in_ready_o = hs | drop;
  assign inflight_o = inflight_q;
  assign stall_cnt_o = stall_q;
  assign busy_o = |inflight_q | |pend_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c_q <= '0;
      k_q <= '0;
      pend_q <= '0;
      inflight_q <= '0;
      stall_q <= '0;
    end else begin
      if (commit_valid_i) begin
        c_q[commit_id_i] <= ~commit_kill_i;
        k_q[commit_id_i] <= commit_kill_i;
      end
      if (in_ready_o) begin
        c_q[in_id_i] <= 1'b0;
        k_q[in_id_i] <= 1'b0;
      end
      pend_q <= (pend_q & ~wb_clr) | ((hs & in_rd_is_fp_i) ? 32'd1 << in_rd_i : 32'd0);
      inflight_q <= inflight_q + 4'(hs) - 4'(retire_i && inflight_q != 4'd0);
      if (in_valid_i & go & ~dead & (|stall_k | waw) & ~&stall_q) stall_q <= stall_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_fpu_ss_dispatch_ctrl.sv
// tb_fpu_ss_dispatch_ctrl: two configurations (bypass/out-of-order and neither) against a rule-level model
module tb_fpu_ss_dispatch_ctrl;
  logic clk = 1'b0, rst_n;
  logic in_valid, in_rd_is_fp, commit_valid, commit_kill, disp_ready, retire;
  logic [3:0] in_id, commit_id;
  logic [14:0] in_rs;
  logic [2:0] in_use_rs;
  logic [4:0] in_rd;
  logic [1:0] wb_valid;
  logic [9:0] wb_rd;
  logic [1:0] dv, ir, dd, by;
  logic [1:0][5:0] fs;
  logic [1:0][3:0] inf;
  logic [1:0][31:0] sc;
  int errors = 0, checks = 0;
  bit mc[2][16], mk[2][16], mp[2][32];
  int mi[2];
  longint ms[2];
  bit e_valid[2], e_drop[2], e_ready[2], e_inc[2];
  logic [5:0] e_fwd[2];

  always #5 clk = ~clk;

  fpu_ss_dispatch_ctrl u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[0]), .in_id_i(in_id),
    .in_rs_i(in_rs), .in_use_rs_i(in_use_rs), .in_rd_i(in_rd), .in_rd_is_fp_i(in_rd_is_fp),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .disp_valid_o(dv[0]), .disp_ready_i(disp_ready), .disp_drop_o(dd[0]), .retire_i(retire),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .fwd_sel_o(fs[0]), .inflight_o(inf[0]),
    .stall_cnt_o(sc[0]), .busy_o(by[0]));

  fpu_ss_dispatch_ctrl #(.FORWARDING(0), .OUT_OF_ORDER(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[1]), .in_id_i(in_id),
    .in_rs_i(in_rs), .in_use_rs_i(in_use_rs), .in_rd_i(in_rd), .in_rd_is_fp_i(in_rd_is_fp),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .disp_valid_o(dv[1]), .disp_ready_i(disp_ready), .disp_drop_o(dd[1]), .retire_i(retire),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .fwd_sel_o(fs[1]), .inflight_o(inf[1]),
    .stall_cnt_o(sc[1]), .busy_o(by[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_valid = 0; in_id = 0; in_rs = 0; in_use_rs = 0; in_rd = 0; in_rd_is_fp = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0; disp_ready = 0; retire = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic model_eval(input int u);
    int lim;
    bit fw, same, go, dead, stall, waw, hit;
    logic [4:0] r;
    lim = (u == 0) ? 4 : 1;
    fw = (u == 0);
    same = commit_valid && commit_id == in_id;
    go = mc[u][in_id] || (same && !commit_kill);
    dead = mk[u][in_id] || (same && commit_kill);
    e_fwd[u] = '0;
    stall = 0;
    for (int k = 0; k < 3; k++) begin
      r = in_rs[5*k +: 5];
      for (int p = 0; p < 2; p++)
        if (fw && wb_valid[p] && wb_rd[5*p +: 5] == r && e_fwd[u][2*k +: 2] == 2'b00) e_fwd[u][2*k + p] = 1'b1;
      if (in_use_rs[k] && mp[u][r] && e_fwd[u][2*k +: 2] == 2'b00) stall = 1;
    end
    hit = 0;
    for (int p = 0; p < 2; p++) if (wb_valid[p] && wb_rd[5*p +: 5] == in_rd) hit = 1;
    waw = in_rd_is_fp && mp[u][in_rd] && !hit;
    e_valid[u] = in_valid && go && !dead && !stall && !waw && !(mi[u] == lim && !retire);
    e_drop[u] = in_valid && dead;
    e_ready[u] = (e_valid[u] && disp_ready) || e_drop[u];
    e_inc[u] = in_valid && go && !dead && (stall || waw);
  endtask

  task automatic model_update(input int u);
    bit dec;
    if (!rst_n) begin
      foreach (mc[u][i]) begin mc[u][i] = 0; mk[u][i] = 0; end
      foreach (mp[u][i]) mp[u][i] = 0;
      mi[u] = 0;
      ms[u] = 0;
    end else begin
      if (commit_valid) begin mc[u][commit_id] = !commit_kill; mk[u][commit_id] = commit_kill; end
      if (e_ready[u]) begin mc[u][in_id] = 0; mk[u][in_id] = 0; end
      for (int p = 0; p < 2; p++) if (wb_valid[p]) mp[u][wb_rd[5*p +: 5]] = 0;
      if (e_valid[u] && disp_ready && in_rd_is_fp) mp[u][in_rd] = 1;
      dec = retire && mi[u] > 0;
      if (e_valid[u] && disp_ready) mi[u]++;
      if (dec) mi[u]--;
      if (e_inc[u] && ms[u] < 64'hFFFF_FFFF) ms[u]++;
    end
  endtask

  task automatic settle();
    bit b;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      model_eval(u);
      b = mi[u] != 0;
      foreach (mp[u][i]) b = b | mp[u][i];
      chk($sformatf("u%0d_disp_valid", u), dv[u], e_valid[u]);
      chk($sformatf("u%0d_disp_drop", u), dd[u], e_drop[u]);
      chk($sformatf("u%0d_in_ready", u), ir[u], e_ready[u]);
      chk($sformatf("u%0d_fwd_sel", u), fs[u], e_fwd[u]);
      chk($sformatf("u%0d_inflight", u), inf[u], mi[u]);
      chk($sformatf("u%0d_stall_cnt", u), sc[u], ms[u]);
      chk($sformatf("u%0d_busy", u), by[u], b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_update(u);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    settle();
    tick();
    rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    for (int u = 0; u < 2; u++) model_update(u);
    #1;
    settle();
    chk("rst_valid", dv[0], 0); chk("rst_ready", ir[0], 0); chk("rst_fwd", fs[0], 0); chk("rst_busy", by[0], 0);
    tick();
    rst_n = 1;
    // head waits for commit, then dispatches in the commit cycle
    in_valid = 1; in_id = 3; in_rd = 5; in_rd_is_fp = 1; disp_ready = 1;
    settle(); chk("r27_wait", dv[0], 0); tick();
    commit_valid = 1; commit_id = 3;
    settle(); chk("r27_go", dv[0], 1); tick();
    idle();
    settle(); chk("r27_inflight", inf[0], 1); chk("r27_busy", by[0], 1); tick();
    // rs1=5 pending, bypassed from wb port 1 only when forwarding is on
    in_valid = 1; in_id = 4; commit_valid = 1; commit_id = 4; in_use_rs = 3'b001; in_rs = 15'd5;
    wb_valid = 2'b10; wb_rd = {5'd5, 5'd7};
    settle(); chk("r28_fwd_valid", dv[0], 1); chk("r28_fwd_sel", fs[0][1:0], 2'b10);
    chk("r28_nofwd_valid", dv[1], 0); chk("r28_nofwd_sel", fs[1], 0); tick();
    idle();
    settle(); chk("r28_stall1", sc[1], 1); chk("r28_stall0", sc[0], 0); tick();
    // killed head drops for exactly one cycle
    in_valid = 1; in_id = 7; commit_valid = 1; commit_id = 7; commit_kill = 1;
    settle(); chk("r29_drop", dd[0], 1); chk("r29_ready", ir[0], 1); chk("r29_valid", dv[0], 0); tick();
    commit_valid = 0; commit_kill = 0;
    settle(); chk("r29_drop_once", dd[0], 0); chk("r29_inflight", inf[0], 1); tick();
    do_reset();
    // in-flight limit of 4, released by a retire in the same cycle
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_id = 4'(i); commit_valid = 1; commit_id = 4'(i); disp_ready = 1;
      settle(); tick();
    end
    in_id = 8; commit_id = 8;
    settle(); chk("r30_limit", dv[0], 0); tick();
    retire = 1;
    settle(); chk("r30_release", dv[0], 1); tick();
    idle();
    settle(); chk("r30_inflight", inf[0], 4); tick();
    do_reset();
    // set beats same-cycle writeback clear; in-order mode waits on retire
    in_valid = 1; in_id = 1; commit_valid = 1; commit_id = 1; in_rd = 9; in_rd_is_fp = 1;
    disp_ready = 1; wb_valid = 2'b01; wb_rd = {5'd0, 5'd9};
    settle(); chk("r31_disp", dv[0], 1); tick();
    in_id = 2; commit_id = 2; wb_valid = 0;
    settle(); chk("r31_waw", dv[0], 0); chk("r31_inorder", dv[1], 0); tick();
    commit_valid = 0; in_rd_is_fp = 0; disp_ready = 0;
    settle(); chk("r31_inorder_wait", dv[1], 0); tick();
    retire = 1;
    settle(); chk("r31_inorder_retire", dv[1], 1); tick();
    do_reset();
    // reset mid-operation wipes in-flight, pending and committed ids
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_id = 4'(i); commit_valid = 1; commit_id = 4'(i); disp_ready = 1;
      in_rd = 5'(2 + i); in_rd_is_fp = (i == 0);
      settle(); tick();
    end
    idle(); commit_valid = 1; commit_id = 10;
    settle(); chk("r32_inflight3", inf[0], 3); tick();
    idle(); rst_n = 0;
    settle(); chk("r32_busy_in_rst", by[0], 1); chk("r32_infl_in_rst", inf[0], 3); tick();
    rst_n = 1; in_valid = 1; in_id = 10; disp_ready = 1;
    settle(); chk("r32_nodisp", dv[0], 0); chk("r32_inflight0", inf[0], 0); chk("r32_busy0", by[0], 0); tick();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_id = 4'($urandom_range(0, 15));
      commit_valid = $urandom_range(0, 1);
      commit_id = $urandom_range(0, 1) ? in_id : 4'($urandom_range(0, 15));
      commit_kill = $urandom_range(0, 3) == 0;
      in_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      in_use_rs = 3'($urandom_range(0, 7));
      in_rd = 5'($urandom_range(0, 7));
      in_rd_is_fp = $urandom_range(0, 1);
      disp_ready = $urandom_range(0, 3) != 0;
      retire = $urandom_range(0, 9) < 3;
      wb_valid = 2'($urandom_range(0, 3));
      wb_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      settle();
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_ss_dispatch_ctrl.md
FPU_SS_DISPATCH_CTRL -- requirements
Module: fpu_ss_dispatch_ctrl

Interface
REQ-001 Params SHALL be (name, default, meaning):
- ID_WIDTH, 4, offload id width.
- MAX_INFLIGHT, 4, FPU ops in flight, 1..15.
- NUM_WB, 2, writeback ports; port 0 has priority.
- FORWARDING, 1, enables bypass.
- OUT_OF_ORDER, 1, when 0 the in-flight limit is forced to 1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset: one clock, synchronous, active-low.
- in_valid_i, in, 1, head instruction of input buffer valid.
- in_ready_o, out, 1, pop head.
- in_id_i, in, ID_WIDTH, head offload id.
- in_rs_i, in, 15, three 5-bit FP source addresses; rs1 is [4:0].
- in_use_rs_i, in, 3, source k read as FP register.
- in_rd_i, in, 5, destination.
- in_rd_is_fp_i, in, 1, rd is an FP register.
- commit_valid_i, in, 1, commit strobe.
- commit_id_i, in, ID_WIDTH, committed id.
- commit_kill_i, in, 1, commit is a kill.
- disp_valid_o, out, 1, dispatch to FPU.
- disp_ready_i, in, 1, FPU accepts.
- disp_drop_o, out, 1, head discarded (killed).
- retire_i, in, 1, FPU result handshake this cycle.
- wb_valid_i, in, NUM_WB, FP register write this cycle.
- wb_rd_i, in, 5*NUM_WB, write addresses.
- fwd_sel_o, out, 3*NUM_WB, per-operand one-hot bypass source.
- inflight_o, out, 4, in-flight count.
- stall_cnt_o, out, 32, dependency-stall cycles.
- busy_o, out, 1, any FPU op in flight or any rd pending.

Function
REQ-003 The id table SHALL hold 2^ID_WIDTH entries of two bits each: committed (C) and killed (K).
REQ-004 On commit_valid_i, entry commit_id_i SHALL set K if commit_kill_i=1, else C.
REQ-005 The head SHALL be "go" when C[in_id_i]=1 or there is a same-cycle non-kill commit of in_id_i.
REQ-006 The head SHALL be "dead" when K[in_id_i]=1 or there is a same-cycle kill commit of in_id_i.
REQ-007 A dead head SHALL assert disp_drop_o=in_ready_o=1 and disp_valid_o=0, and SHALL clear its id entry; drop takes 1 cycle.
REQ-008 The rd scoreboard SHALL be 32 pending bits; x0 is not special (FP file).
REQ-009 Operand k SHALL stall when in_use_rs_i[k] & pending[rs_k] and there is no bypass for it.
REQ-010 A bypass SHALL exist when FORWARDING=1 and some wb_valid_i[p] has wb_rd_i[p]==rs_k; fwd_sel_o[k] is one-hot on the lowest such p, else 0.
REQ-011 With FORWARDING=0, fwd_sel_o SHALL be 0.
REQ-012 WAW stall SHALL occur when in_rd_is_fp_i & pending[in_rd_i] and no wb port writes in_rd_i in that cycle.
REQ-013 The limit SHALL be reached when inflight==LIMIT & ~retire_i, where LIMIT=MAX_INFLIGHT if OUT_OF_ORDER, else 1.
REQ-014 disp_valid_o SHALL equal in_valid_i & go & ~dead & ~any stall & ~limit; it is combinational, zero latency.
REQ-015 in_ready_o SHALL be 1 on dispatch handshake (disp_valid_o & disp_ready_i) or on drop.
REQ-016 Dispatch handshake SHALL clear id entry in_id_i.
REQ-017 Dispatch handshake with in_rd_is_fp_i SHALL set pending[in_rd_i].
REQ-018 Each wb_valid_i[p] SHALL clear pending[wb_rd_i[p]].
REQ-019 When a set and a clear hit the same register in one cycle, set SHALL win.
REQ-020 inflight SHALL be +1 on handshake and -1 on retire_i; both in one cycle leaves it unchanged.
REQ-021 retire_i at inflight=0 SHALL be ignored (no underflow).
REQ-022 stall_cnt_o SHALL increment each cycle in_valid_i & go & ~dead & (operand stall | WAW stall), saturating at 32'hFFFF_FFFF.
REQ-023 A commit to an id whose entry is already set SHALL overwrite it: K and C become exclusive, last write wins.

Reset
REQ-024 When rst_ni=0 at a clk_i edge, the id table, scoreboard, inflight and stall_cnt_o SHALL clear to 0.
REQ-025 While reset is sampled, the combinational outputs SHALL still be functions of the cleared state; no in-flight op survives reset mid-operation.
REQ-026 After reset: disp_valid_o=0, in_ready_o=0, fwd_sel_o=0, busy_o=0 until inputs drive them.

Verification
REQ-027 Head id=3 with no commit, then commit id=3 (no kill) -> disp_valid_o rises that same cycle; after handshake with rd=5 fp, pending[5]=1 and inflight_o=1.
REQ-028 pending[5]=1, head rs1=5 used, wb_valid_i[1]=1 with wb_rd=5 -> disp_valid_o=1, fwd_sel_o[1:0]=2'b10; with FORWARDING=0 -> disp_valid_o=0 and stall_cnt_o increments.
REQ-029 Head id=7 killed by commit_kill_i -> disp_drop_o=1 and in_ready_o=1 for one cycle, disp_valid_o=0, inflight_o unchanged.
REQ-030 MAX_INFLIGHT=4 with 4 dispatched -> 5th stalls; cycle with retire_i=1 -> 5th dispatches and inflight_o stays 4.
REQ-031 Dispatch rd=9 while wb writes rd=9 same cycle -> pending[9]=1; OUT_OF_ORDER=0 -> second dispatch waits until inflight_o=0 or retire_i.
REQ-032 Reset asserted with inflight_o=3, pending[2]=1 -> next cycle all 0; a head already committed before reset does not dispatch.
